// File: rtl/reg_bank8_writer.sv
// Write side of the 8 x 16-bit general register file: accepts one LOAD/MOVE/CLEAR/INC
// command over a req/busy/done handshake and writes exactly one register through a one-hot enable.
module reg_bank8_writer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [2:0]       dst,
  input  logic [2:0]       src,
  input  logic [WIDTH-1:0] DIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7
);

  localparam int unsigned SELW = 3;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_MOVE  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_INC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    WRITE = 2'b10
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [SELW-1:0] dst;
    logic [SELW-1:0] src;
    logic [WIDTH-1:0] din;
  } cmd_t;

  state_e           state, state_d;
  cmd_t             hold;
  logic [WIDTH-1:0] temp;
  logic [WIDTH-1:0] regs [NREGS];
  logic             ld_hold, ld_temp, wr_en;
  logic [WIDTH-1:0] operand;
  logic [NREGS-1:0] wr_onehot;

  // Next-state and per-state control strobes
  always_comb begin
    state_d = state;
    ld_hold = 1'b0;
    ld_temp = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          ld_hold = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ld_temp = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand selection; INC wraps silently at the register width
  always_comb begin
    operand = '0;
    unique case (hold.op)
      OP_LOAD:  operand = hold.din;
      OP_MOVE:  operand = regs[hold.src];
      OP_CLEAR: operand = '0;
      OP_INC:   operand = regs[hold.src] + WIDTH'(1);
      default:  operand = '0;
    endcase
  end

  assign wr_onehot = NREGS'(1) << hold.dst;
  assign busy      = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      hold  <= '0;
      temp  <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_d;
      done  <= wr_en;
      if (ld_hold) hold <= '{op: op_e'(op), dst: dst, src: src, din: DIN};
      if (ld_temp) temp <= operand;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_en && wr_onehot[i]) regs[i] <= temp;
      end
    end
  end

  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];
  assign R4 = regs[4];
  assign R5 = regs[5];
  assign R6 = regs[6];
  assign R7 = regs[7];

endmodule
